// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : shares one memory port between a fetch and a data requester,
//               one access in flight, alternating priority on contention.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_stall,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_re,
  output logic              m_we,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] C_LAT_INIT = 4'(MEM_LAT - 1);
  localparam logic       OWNER_IF   = 1'b0;
  localparam logic       OWNER_D    = 1'b1;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                owner_q, owner_d;
  logic                last_owner_q, last_owner_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                grant_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      owner_q      <= OWNER_IF;
      last_owner_q <= OWNER_IF;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    grant_data   = 1'b0;
    m_addr       = '0;
    m_wdata      = '0;
    m_re         = 1'b0;
    m_we         = 1'b0;
    if_ack       = 1'b0;
    d_ack        = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          // On contention the port that did not win last time gets the grant
          grant_data = d_req && (!if_req || (last_owner_q == OWNER_IF));
          owner_d    = grant_data ? OWNER_D : OWNER_IF;
          addr_d     = grant_data ? d_addr : if_addr;
          wdata_d    = grant_data ? d_wdata : '0;
          we_d       = grant_data ? d_we : 1'b0;
          cnt_d      = C_LAT_INIT;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        m_addr  = addr_q;
        m_wdata = wdata_q;
        m_we    = we_q;
        m_re    = !we_q;
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (owner_q == OWNER_D) d_rdata_d  = m_rdata;
            else                    if_rdata_d = m_rdata;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if_ack       = (owner_q == OWNER_IF);
        d_ack        = (owner_q == OWNER_D);
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_stall = if_req && !if_ack;
  assign d_stall  = d_req && !d_ack;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed and randomized checks of mem_arbiter (MEM_LAT=2)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int L  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr, m_addr;
  logic [DW-1:0] d_wdata, if_rdata, d_rdata, m_wdata, m_rdata;
  logic          if_ack, if_stall, d_ack, d_stall, m_re, m_we;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_stall(d_stall),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_re(m_re), .m_we(m_we), .m_rdata(m_rdata)
  );

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return (a == 32'h10) ? 32'h8C010004 : ((a * 32'h9E3779B1) ^ 32'h13572468);
  endfunction

  // Memory returns real data only once the read has been held for L cycles
  int            held;
  logic [AW-1:0] held_addr;
  always @(posedge clk) begin
    if (m_re) held <= (held != 0 && m_addr == held_addr) ? held + 1 : 1;
    else      held <= 0;
    held_addr <= m_addr;
  end
  assign m_rdata = (m_re && held >= L - 1) ? mem_val(m_addr) : 32'hBADC0DE5;

  task automatic do_reset();
    rst = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({if_ack, d_ack, m_re, m_we, if_stall, d_stall} !== 6'b000011) begin
        n_err++; $display("FAIL reset_flags k=%0d got=%b exp=000011", k, {if_ack, d_ack, m_re, m_we, if_stall, d_stall});
      end
      n_cmp++;
      if ({m_addr, m_wdata, if_rdata, d_rdata} !== '0) begin
        n_err++; $display("FAIL reset_data k=%0d got=%h/%h/%h/%h exp=0", k, m_addr, m_wdata, if_rdata, d_rdata);
      end
    end
  endtask

  task automatic test_fetch_only();
    logic [5:0]    ef;
    logic [DW-1:0] erd;
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) if_req = 1'b0;
      @(negedge clk);
      ef  = {c == 1 || c == 2, 1'b0, c == 3, 1'b0, c <= 2, 1'b0};
      erd = (c >= 3) ? 32'h8C010004 : 32'h0;
      n_cmp++;
      if ({m_re, m_we, if_ack, d_ack, if_stall, d_stall} !== ef) begin
        n_err++; $display("FAIL fetch_flags c=%0d got=%b exp=%b", c, {m_re, m_we, if_ack, d_ack, if_stall, d_stall}, ef);
      end
      n_cmp++;
      if (m_addr !== ((c == 1 || c == 2) ? 32'h10 : 32'h0)) begin
        n_err++; $display("FAIL fetch_addr c=%0d got=%h", c, m_addr);
      end
      n_cmp++;
      if (if_rdata !== erd) begin
        n_err++; $display("FAIL fetch_rdata c=%0d got=%h exp=%h", c, if_rdata, erd);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_only();
    logic [5:0] ef;
    logic       act;
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) begin d_addr = 32'h999; d_wdata = 32'h12345678; d_we = 1'b0; end
      if (c == 4) d_req = 1'b0;
      @(negedge clk);
      act = (c == 1 || c == 2);
      ef  = {1'b0, act, 1'b0, c == 3, 1'b0, c <= 2};
      n_cmp++;
      if ({m_re, m_we, if_ack, d_ack, if_stall, d_stall} !== ef) begin
        n_err++; $display("FAIL store_flags c=%0d got=%b exp=%b", c, {m_re, m_we, if_ack, d_ack, if_stall, d_stall}, ef);
      end
      n_cmp++;
      if ({m_addr, m_wdata} !== (act ? {32'h20, 32'hDEADBEEF} : 64'h0)) begin
        n_err++; $display("FAIL store_bus c=%0d got=%h/%h", c, m_addr, m_wdata);
      end
      n_cmp++;
      if (d_rdata !== 32'h0) begin
        n_err++; $display("FAIL store_rdata c=%0d got=%h exp=0", c, d_rdata);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_contention();
    logic [5:0]    ef;
    logic [AW-1:0] ea;
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    for (int c = 0; c < 9; c++) begin
      if (c == 4) d_req = 1'b0;
      if (c == 8) if_req = 1'b0;
      @(negedge clk);
      ef = {c == 1 || c == 2 || c == 5 || c == 6, 1'b0, c == 7, c == 3, c <= 6, c <= 2};
      ea = (c == 1 || c == 2) ? 32'h80 : (c == 5 || c == 6) ? 32'h10 : 32'h0;
      n_cmp++;
      if ({m_re, m_we, if_ack, d_ack, if_stall, d_stall} !== ef) begin
        n_err++; $display("FAIL contend_flags c=%0d got=%b exp=%b", c, {m_re, m_we, if_ack, d_ack, if_stall, d_stall}, ef);
      end
      n_cmp++;
      if (m_addr !== ea) begin
        n_err++; $display("FAIL contend_addr c=%0d got=%h exp=%h", c, m_addr, ea);
      end
      n_cmp++;
      if ({d_rdata, if_rdata} !== {(c >= 3) ? mem_val(32'h80) : 32'h0, (c >= 7) ? 32'h8C010004 : 32'h0}) begin
        n_err++; $display("FAIL contend_rdata c=%0d got=%h/%h", c, d_rdata, if_rdata);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alternation();
    logic [1:0] ea;
    do_reset();
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      ea = {c == 7 || c == 15, c == 3 || c == 11};
      n_cmp++;
      if ({if_ack, d_ack} !== ea) begin
        n_err++; $display("FAIL alternate_acks c=%0d got=%b exp=%b", c, {if_ack, d_ack}, ea);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_drop();
    logic [5:0] ef;
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;
    for (int c = 0; c < 7; c++) begin
      if (c == 1) begin if_req = 1'b0; if_addr = 32'h55; end
      @(negedge clk);
      ef = {c == 1 || c == 2, 1'b0, c == 3, 1'b0, c == 0, 1'b0};
      n_cmp++;
      if ({m_re, m_we, if_ack, d_ack, if_stall, d_stall} !== ef) begin
        n_err++; $display("FAIL drop_flags c=%0d got=%b exp=%b", c, {m_re, m_we, if_ack, d_ack, if_stall, d_stall}, ef);
      end
      n_cmp++;
      if ({m_addr, if_rdata} !== {(c == 1 || c == 2) ? 32'h10 : 32'h0, (c >= 3) ? 32'h8C010004 : 32'h0}) begin
        n_err++; $display("FAIL drop_data c=%0d got=%h/%h", c, m_addr, if_rdata);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] ef;
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) rst = 1'b0;
      if (c == 3) rst = 1'b1;
      if (c == 7) d_req = 1'b0;
      @(negedge clk);
      ef = {c == 1 || c == 4 || c == 5, c == 6, c <= 5};
      n_cmp++;
      if ({m_re, d_ack, d_stall} !== ef) begin
        n_err++; $display("FAIL rstmid_flags c=%0d got=%b exp=%b", c, {m_re, d_ack, d_stall}, ef);
      end
      n_cmp++;
      if (d_rdata !== ((c >= 6) ? mem_val(32'h40) : 32'h0)) begin
        n_err++; $display("FAIL rstmid_rdata c=%0d got=%h", c, d_rdata);
      end
      @(posedge clk); #1;
    end
  endtask

  // Transaction-level model: a grant at cycle g owns the bus for cycles
  // g+1..g+L, acks at g+L+1 and frees the arbiter for cycle g+L+2.
  task automatic test_random();
    bit            busy = 0, own = 0, last = 0, we_s = 0;
    int            g = 0;
    logic [AW-1:0] addr_s = '0;
    logic [DW-1:0] wd_s = '0, rd_if = '0, rd_d = '0;
    bit            act, ack;
    logic [5:0]    ef;
    do_reset();
    for (int t = 0; t < 500; t++) begin
      if_req  = ($urandom_range(0, 99) < 60);
      d_req   = ($urandom_range(0, 99) < 60);
      d_we    = $urandom_range(0, 1) == 1;
      if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
      act = busy && (t >= g + 1) && (t <= g + L);
      ack = busy && (t == g + L + 1);
      ef  = {act && !we_s, act && we_s, ack && !own, ack && own,
             if_req && !(ack && !own), d_req && !(ack && own)};
      @(negedge clk);
      n_cmp++;
      if ({m_re, m_we, if_ack, d_ack, if_stall, d_stall} !== ef) begin
        n_err++; $display("FAIL rand_flags t=%0d got=%b exp=%b", t, {m_re, m_we, if_ack, d_ack, if_stall, d_stall}, ef);
      end
      n_cmp++;
      if (m_addr !== (act ? addr_s : '0)) begin
        n_err++; $display("FAIL rand_addr t=%0d got=%h exp=%h", t, m_addr, act ? addr_s : '0);
      end
      if (!(act && !we_s)) begin
        n_cmp++;
        if (m_wdata !== (act ? wd_s : '0)) begin
          n_err++; $display("FAIL rand_wdata t=%0d got=%h exp=%h", t, m_wdata, act ? wd_s : '0);
        end
      end
      n_cmp++;
      if ({if_rdata, d_rdata} !== {rd_if, rd_d}) begin
        n_err++; $display("FAIL rand_rdata t=%0d got=%h/%h exp=%h/%h", t, if_rdata, d_rdata, rd_if, rd_d);
      end
      if (busy && t == g + L && !we_s) begin
        if (own) rd_d = mem_val(addr_s);
        else     rd_if = mem_val(addr_s);
      end
      if (ack) begin
        last = own; busy = 0;
      end else if (!busy && (if_req || d_req)) begin
        busy = 1; g = t;
        own  = (if_req && d_req) ? !last : d_req;
        addr_s = own ? d_addr : if_addr;
        wd_s   = own ? d_wdata : '0;
        we_s   = own ? d_we : 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b0;
    #1;
    test_reset();
    test_fetch_only();
    test_store_only();
    test_contention();
    test_alternation();
    test_drop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired compared=%0d mismatched=%0d", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
